// File: rtl/matrix_row_loader_pkg.sv
// Shared definitions for the LED-matrix row loader:
// FSM state encoding, row count and the four level pattern ROMs.
package matrix_row_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } loaderState_t;

    localparam int         ROW_COUNT   = 8;
    localparam int         INDEX_WIDTH = 3;
    localparam logic [2:0] LAST_ROW    = 3'd7;

    // Element [i] is the pattern for row i.
    localparam logic [7:0][7:0] LEVEL0_ROM = {
        8'h80, 8'h40, 8'h20, 8'h10,
        8'h08, 8'h04, 8'h02, 8'h01
    };
    localparam logic [7:0][7:0] LEVEL1_ROM = {
        8'hFF, 8'hFF, 8'hFF, 8'hFF,
        8'hFF, 8'hFF, 8'hFF, 8'hFF
    };
    localparam logic [7:0][7:0] LEVEL2_ROM = {
        8'h55, 8'hAA, 8'h55, 8'hAA,
        8'h55, 8'hAA, 8'h55, 8'hAA
    };
    localparam logic [7:0][7:0] LEVEL3_ROM = {
        8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00
    };

endpackage

// File: rtl/matrix_level_rom.sv
// Combinational level pattern table.
// Ports: level (pattern select), rowIndex (row 0..7) -> rowData (row bits).
module matrix_level_rom
    import matrix_row_loader_pkg::*;
#(
    parameter int MATRIXLOADER_DATAWIDTH  = 8,
    parameter int MATRIXLOADER_LEVELWIDTH = 2
) (
    input  logic [MATRIXLOADER_LEVELWIDTH-1:0] level,
    input  logic [INDEX_WIDTH-1:0]             rowIndex,
    output logic [MATRIXLOADER_DATAWIDTH-1:0]  rowData
);

    always_comb begin
        rowData = '0;
        case (int'(level))
            0:       rowData = MATRIXLOADER_DATAWIDTH'(LEVEL0_ROM[rowIndex]);
            1:       rowData = MATRIXLOADER_DATAWIDTH'(LEVEL1_ROM[rowIndex]);
            2:       rowData = MATRIXLOADER_DATAWIDTH'(LEVEL2_ROM[rowIndex]);
            3:       rowData = MATRIXLOADER_DATAWIDTH'(LEVEL3_ROM[rowIndex]);
            default: rowData = '0;
        endcase
    end

endmodule

// File: rtl/matrix_row_loader.sv
// Loads one of four level patterns into the eight LED-matrix row registers,
// one row per clock, or zeroes all rows in a single clock.
// Ports: CLOCK_50 / RESET_InHigh (async, active high), load_InHigh,
//   clear_InHigh, level_InBUS in; registro7..0_OutBUS, busy_OutHigh,
//   done_OutHigh out (all registered).
module matrix_row_loader
    import matrix_row_loader_pkg::*;
#(
    parameter int MATRIXLOADER_DATAWIDTH  = 8,
    parameter int MATRIXLOADER_LEVELWIDTH = 2
) (
    input  logic                               MATRIXLOADER_CLOCK_50,
    input  logic                               MATRIXLOADER_RESET_InHigh,
    input  logic                               MATRIXLOADER_load_InHigh,
    input  logic                               MATRIXLOADER_clear_InHigh,
    input  logic [MATRIXLOADER_LEVELWIDTH-1:0] MATRIXLOADER_level_InBUS,
    output logic [MATRIXLOADER_DATAWIDTH-1:0]  MATRIXLOADER_registro7_OutBUS,
    output logic [MATRIXLOADER_DATAWIDTH-1:0]  MATRIXLOADER_registro6_OutBUS,
    output logic [MATRIXLOADER_DATAWIDTH-1:0]  MATRIXLOADER_registro5_OutBUS,
    output logic [MATRIXLOADER_DATAWIDTH-1:0]  MATRIXLOADER_registro4_OutBUS,
    output logic [MATRIXLOADER_DATAWIDTH-1:0]  MATRIXLOADER_registro3_OutBUS,
    output logic [MATRIXLOADER_DATAWIDTH-1:0]  MATRIXLOADER_registro2_OutBUS,
    output logic [MATRIXLOADER_DATAWIDTH-1:0]  MATRIXLOADER_registro1_OutBUS,
    output logic [MATRIXLOADER_DATAWIDTH-1:0]  MATRIXLOADER_registro0_OutBUS,
    output logic                               MATRIXLOADER_busy_OutHigh,
    output logic                               MATRIXLOADER_done_OutHigh
);

    loaderState_t                        state;
    loaderState_t                        nextState;
    logic [INDEX_WIDTH-1:0]              rowIndex;
    logic [MATRIXLOADER_LEVELWIDTH-1:0]  levelLatched;
    logic [MATRIXLOADER_DATAWIDTH-1:0]   romRow;
    logic [MATRIXLOADER_DATAWIDTH-1:0]   rowRegs [ROW_COUNT];
    logic                                busyReg;
    logic                                doneReg;

    matrix_level_rom #(
        .MATRIXLOADER_DATAWIDTH  (MATRIXLOADER_DATAWIDTH),
        .MATRIXLOADER_LEVELWIDTH (MATRIXLOADER_LEVELWIDTH)
    ) levelRom (
        .level    (levelLatched),
        .rowIndex (rowIndex),
        .rowData  (romRow)
    );

    always_ff @(posedge MATRIXLOADER_CLOCK_50 or posedge MATRIXLOADER_RESET_InHigh) begin
        if (MATRIXLOADER_RESET_InHigh) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Clear has priority everywhere it is honoured, including aborting a load.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (MATRIXLOADER_clear_InHigh) begin
                    nextState = CLEAR;
                end else if (MATRIXLOADER_load_InHigh) begin
                    nextState = LOAD;
                end
            end
            LOAD: begin
                if (MATRIXLOADER_clear_InHigh) begin
                    nextState = CLEAR;
                end else if (rowIndex == LAST_ROW) begin
                    nextState = DONE;
                end
            end
            CLEAR: nextState = DONE;
            DONE:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Busy/done are derived from the next state so they line up with it.
    always_ff @(posedge MATRIXLOADER_CLOCK_50 or posedge MATRIXLOADER_RESET_InHigh) begin
        if (MATRIXLOADER_RESET_InHigh) begin
            rowIndex     <= '0;
            levelLatched <= '0;
            rowRegs      <= '{default: '0};
            busyReg      <= 1'b0;
            doneReg      <= 1'b0;
        end else begin
            busyReg <= (nextState == LOAD) || (nextState == CLEAR);
            doneReg <= (nextState == DONE);
            unique case (state)
                IDLE: begin
                    if (!MATRIXLOADER_clear_InHigh && MATRIXLOADER_load_InHigh) begin
                        levelLatched <= MATRIXLOADER_level_InBUS;
                        rowIndex     <= '0;
                    end
                end
                LOAD: begin
                    // The row in flight is still written on an aborting edge.
                    rowRegs[rowIndex] <= romRow;
                    rowIndex          <= rowIndex + 3'd1;
                end
                CLEAR: begin
                    rowRegs <= '{default: '0};
                end
                default: ;
            endcase
        end
    end

    assign MATRIXLOADER_registro0_OutBUS = rowRegs[0];
    assign MATRIXLOADER_registro1_OutBUS = rowRegs[1];
    assign MATRIXLOADER_registro2_OutBUS = rowRegs[2];
    assign MATRIXLOADER_registro3_OutBUS = rowRegs[3];
    assign MATRIXLOADER_registro4_OutBUS = rowRegs[4];
    assign MATRIXLOADER_registro5_OutBUS = rowRegs[5];
    assign MATRIXLOADER_registro6_OutBUS = rowRegs[6];
    assign MATRIXLOADER_registro7_OutBUS = rowRegs[7];
    assign MATRIXLOADER_busy_OutHigh     = busyReg;
    assign MATRIXLOADER_done_OutHigh     = doneReg;

endmodule

// File: tb/tb_matrix_row_loader.sv
// Scoreboard bench for matrix_row_loader: each cycle's expected rows,
// busy and done are queued by the stimulus and compared on the falling edge.
module tb_matrix_row_loader;

    logic       clk;
    logic       rst;
    logic       load;
    logic       clear;
    logic [1:0] level;
    logic [7:0] r7, r6, r5, r4, r3, r2, r1, r0;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic [63:0] rows;
        logic        busy;
        logic        done;
    } expEntry_t;

    expEntry_t  scoreQ [$];
    string      tagQ [$];
    logic [7:0] expRows [8];
    int         testsRun;
    int         testsFailed;

    matrix_row_loader dut (
        .MATRIXLOADER_CLOCK_50         (clk),
        .MATRIXLOADER_RESET_InHigh     (rst),
        .MATRIXLOADER_load_InHigh      (load),
        .MATRIXLOADER_clear_InHigh     (clear),
        .MATRIXLOADER_level_InBUS      (level),
        .MATRIXLOADER_registro7_OutBUS (r7),
        .MATRIXLOADER_registro6_OutBUS (r6),
        .MATRIXLOADER_registro5_OutBUS (r5),
        .MATRIXLOADER_registro4_OutBUS (r4),
        .MATRIXLOADER_registro3_OutBUS (r3),
        .MATRIXLOADER_registro2_OutBUS (r2),
        .MATRIXLOADER_registro1_OutBUS (r1),
        .MATRIXLOADER_registro0_OutBUS (r0),
        .MATRIXLOADER_busy_OutHigh     (busy),
        .MATRIXLOADER_done_OutHigh     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] obsRows();
        return {r7, r6, r5, r4, r3, r2, r1, r0};
    endfunction

    function automatic logic [63:0] packExp();
        logic [63:0] p;
        for (int i = 0; i < 8; i++) p[i*8 +: 8] = expRows[i];
        return p;
    endfunction

    function automatic logic [7:0] romRow(input int lvl, input int i);
        logic [7:0] one;
        one = 8'h01;
        case (lvl)
            0:       return one << i;
            1:       return 8'hFF;
            2:       return (i % 2 == 0) ? 8'hAA : 8'h55;
            default: return 8'h00;
        endcase
    endfunction

    function automatic void zeroExp();
        for (int i = 0; i < 8; i++) expRows[i] = 8'h00;
    endfunction

    // Queue the expectation for the cycle that follows the next rising edge.
    task automatic tick(input string tag, input logic b, input logic d);
        @(posedge clk);
        #1;
        scoreQ.push_back({packExp(), b, d});
        tagQ.push_back(tag);
    endtask

    always @(negedge clk) begin : monitor
        expEntry_t e;
        string     t;
        if (scoreQ.size() > 0) begin
            e = scoreQ.pop_front();
            t = tagQ.pop_front();
            checkEq({t, "_rows"}, obsRows(), e.rows);
            checkEq({t, "_busydone"}, {62'b0, busy, done},
                    {62'b0, e.busy, e.done});
        end
    end

    task automatic loadLevel(input int lvl, input bit hold,
                             input int changeAt, input int newLvl);
        load  = 1'b1;
        level = 2'(lvl);
        tick("ld_start", 1'b1, 1'b0);
        if (!hold) load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == changeAt) level = 2'(newLvl);
            expRows[i] = romRow(lvl, i);
            tick($sformatf("ld%0d_row%0d", lvl, i), i < 7, i == 7);
        end
        tick("ld_idle", 1'b0, 1'b0);
        load = 1'b0;
        tick("ld_idle2", 1'b0, 1'b0);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst   = 1'b1;
        load  = 1'b0;
        clear = 1'b0;
        level = 2'd0;
        zeroExp();
        repeat (2) @(posedge clk);
        #1;
        checkEq("rst_rows", obsRows(), 64'd0);
        checkEq("rst_busydone", {62'b0, busy, done}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) tick("idle", 1'b0, 1'b0);

        loadLevel(0, 1'b0, -1, 0);

        // Level bus moves mid-load and load stays high through DONE.
        loadLevel(2, 1'b1, 2, 1);

        // Level 1 load aborted by clear during the 4th LOAD cycle.
        load  = 1'b1;
        level = 2'd1;
        tick("ab_start", 1'b1, 1'b0);
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) clear = 1'b1;
            expRows[i] = 8'hFF;
            tick($sformatf("ab_row%0d", i), 1'b1, 1'b0);
        end
        clear = 1'b0;
        zeroExp();
        tick("ab_clear", 1'b0, 1'b1);
        tick("ab_idle", 1'b0, 1'b0);
        tick("ab_idle2", 1'b0, 1'b0);

        // Preload all rows with 0xFF, then load and clear together.
        loadLevel(1, 1'b0, -1, 0);
        load  = 1'b1;
        clear = 1'b1;
        level = 2'd0;
        tick("both_clear", 1'b1, 1'b0);
        load  = 1'b0;
        clear = 1'b0;
        zeroExp();
        tick("both_done", 1'b0, 1'b1);
        checkEq("crash_flag", {63'b0, ~|obsRows()}, 64'd1);
        tick("both_idle", 1'b0, 1'b0);

        // Reset in the middle of a level 1 load after five rows.
        load  = 1'b1;
        level = 2'd1;
        tick("rl_start", 1'b1, 1'b0);
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expRows[i] = 8'hFF;
            tick($sformatf("rl_row%0d", i), 1'b1, 1'b0);
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        zeroExp();
        checkEq("rl_rst_rows", obsRows(), 64'd0);
        checkEq("rl_rst_busydone", {62'b0, busy, done}, 64'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            checkEq("rl_rst_done", {63'b0, done}, 64'd0);
        end
        rst = 1'b0;
        loadLevel(3, 1'b0, -1, 0);

        @(negedge clk);
        #1;
        checkEq("drain", 64'(scoreQ.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
